// File: rtl/mem_access_if.sv
// mem_access_if: bundle of pipeline, data-memory and DMA signals around the MEM stage
// slave  : MEM-stage view (mem_access), consumes ex_bus/memory/DMA inputs
// master : environment view (pipeline, memory, DMA engine)
interface mem_access_if #(
   parameter int N = 51
);
   logic [N:0]  ex_bus;
   logic [38:0] wb_bus;
   logic        stall;
   logic        mem_req;
   logic        mem_we;
   logic [15:0] mem_addr;
   logic [15:0] mem_wdata;
   logic [15:0] mem_rdata;
   logic        mem_ack;
   logic        dma_req;
   logic        dma_gnt;
   logic        dma_we;
   logic [15:0] dma_addr;
   logic [15:0] dma_wdata;
   logic [15:0] dma_rdata;
   logic        dma_ack;

   modport slave (
      input  ex_bus, mem_rdata, mem_ack, dma_req, dma_we, dma_addr, dma_wdata,
      output wb_bus, stall, mem_req, mem_we, mem_addr, mem_wdata, dma_gnt, dma_rdata, dma_ack
   );

   modport master (
      output ex_bus, mem_rdata, mem_ack, dma_req, dma_we, dma_addr, dma_wdata,
      input  wb_bus, stall, mem_req, mem_we, mem_addr, mem_wdata, dma_gnt, dma_rdata, dma_ack
   );
endinterface

// File: rtl/mem_access.sv
// mem_access: MEM pipeline stage sharing one data-memory port between the CPU and a DMA master
// clk    : single clock, all state on posedge
// rst_n  : asynchronous active-low reset
// bus    : ex_bus in (EXE/MEM bundle), wb_bus out (registered MEM/WB bundle), stall out,
//          mem_* data-memory request/response, dma_* DMA request/grant/response
module mem_access #(
   parameter int N      = 51,
   parameter int STARVE = 4
) (
   input logic         clk,
   input logic         rst_n,
   mem_access_if.slave bus
);
   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_ACCESS = 2'd1;
   localparam logic [1:0] S_DMA    = 2'd2;

   logic [1:0]  state, state_nxt;
   logic [2:0]  starve_cnt, starve_nxt;
   logic [38:0] wb_nxt;
   logic        dma_gnt_q;
   logic        memop, rd_only, dma_win, cpu_sel, dma_sel, unused;

   assign memop   = bus.ex_bus[N-2] | bus.ex_bus[N-3];
   // read+write together is executed as a write, so only a pure read returns data
   assign rd_only = bus.ex_bus[N-2] & ~bus.ex_bus[N-3];
   assign dma_win = (state == S_IDLE) && bus.dma_req && (!memop || starve_cnt >= 3'(STARVE));
   // rst_n gates the CPU path so a memop held on ex_bus cannot reach memory while in reset
   assign cpu_sel = rst_n && ((state == S_ACCESS) || ((state == S_IDLE) && memop && !dma_win));
   assign dma_sel = state == S_DMA;
   assign unused  = ^bus.ex_bus[N-41:0];

   // ex_bus is held by upstream while stalled, so CPU request fields come straight from it
   assign bus.stall     = (state == S_IDLE) ? memop : (state == S_ACCESS) ? !bus.mem_ack : 1'b1;
   assign bus.mem_req   = cpu_sel || (dma_sel && bus.dma_req);
   assign bus.mem_we    = cpu_sel ? bus.ex_bus[N-3] : dma_sel && bus.dma_we;
   assign bus.mem_addr  = cpu_sel ? bus.ex_bus[N-4 -: 16] : dma_sel ? bus.dma_addr : 16'h0;
   assign bus.mem_wdata = cpu_sel ? bus.ex_bus[N-20 -: 16] : dma_sel ? bus.dma_wdata : 16'h0;
   assign bus.dma_rdata = bus.mem_rdata;
   assign bus.dma_ack   = dma_sel && bus.mem_ack;
   assign bus.dma_gnt   = dma_gnt_q;

   always_comb begin
      // a stalled edge writes a bubble so the held instruction retires exactly once
      wb_nxt     = bus.stall ? 39'h0 : {bus.ex_bus[N], bus.ex_bus[N-1],
                                        (state == S_ACCESS && rd_only) ? bus.mem_rdata : 16'h0,
                                        bus.ex_bus[N-4 -: 16], bus.ex_bus[N-36 -: 5]};
      state_nxt  = dma_win ? S_DMA :
                   (state == S_IDLE)   ? (memop ? S_ACCESS : S_IDLE) :
                   (state == S_ACCESS) ? (bus.mem_ack ? S_IDLE : S_ACCESS) :
                   (dma_sel && bus.dma_req) ? S_DMA : S_IDLE;
      starve_nxt = (!bus.dma_req || dma_win || dma_gnt_q) ? 3'd0 :
                   (starve_cnt == 3'd7) ? 3'd7 : starve_cnt + 3'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         starve_cnt <= 3'd0;
         dma_gnt_q  <= 1'b0;
         bus.wb_bus <= 39'h0;
      end else begin
         state      <= state_nxt;
         starve_cnt <= starve_nxt;
         dma_gnt_q  <= state_nxt == S_DMA;
         bus.wb_bus <= wb_nxt;
      end
   end
endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: self-checking bench for mem_access with a writeback scoreboard
module tb_mem_access;
   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;
   logic [38:0] exp_q[$];
   logic [38:0] mon_exp;

   mem_access_if #(.N(51)) bus();

   mem_access #(.N(51), .STARVE(4)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   // every non-bubble writeback must match the oldest expected entry
   always @(negedge clk) begin
      if (rst_n && bus.wb_bus !== 39'h0) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL wb_unexpected got %h want nothing", bus.wb_bus);
         end else begin
            mon_exp = exp_q.pop_front();
            if (bus.wb_bus !== mon_exp) begin
               errors++;
               $display("FAIL wb_bus got %h want %h", bus.wb_bus, mon_exp);
            end
         end
      end
   end

   function automatic logic [51:0] mk(input logic rw, input logic m2r, input logic rd_op,
                                      input logic wr_op, input logic [15:0] alu,
                                      input logic [15:0] sd, input logic [4:0] rd);
      return {rw, m2r, rd_op, wr_op, alu, sd, rd, 11'h5A5};
   endfunction

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   // drives one CPU memop and its memory response; ack arrives delay cycles after the request
   task automatic cpu_access(input logic [51:0] ex, input logic [15:0] rdata, input int delay);
      logic [35:0] got, want;
      exp_q.push_back({ex[51], ex[50], (ex[49] && !ex[48]) ? rdata : 16'h0, ex[47:32], ex[15:11]});
      bus.ex_bus = ex;
      for (int i = 0; i <= delay; i++) begin
         bus.mem_ack   = (i == delay);
         bus.mem_rdata = (i == delay) ? rdata : 16'hDEAD;
         #1;
         got  = {bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.stall, bus.dma_gnt};
         want = {1'b1, ex[48], ex[47:32], ex[31:16], i != delay, 1'b0};
         checks++;
         if (got !== want) begin
            errors++;
            $display("FAIL cpu_access cycle %0d got %h want %h", i, got, want);
         end
         step();
      end
      bus.mem_ack = 1'b0;
      bus.ex_bus  = '0;
   endtask

   task automatic test_reset;
      rst_n = 1'b1;
      bus.ex_bus = '0; bus.mem_rdata = '0; bus.mem_ack = 1'b0;
      bus.dma_req = 1'b0; bus.dma_we = 1'b0; bus.dma_addr = '0; bus.dma_wdata = '0;
      #1;
      rst_n = 1'b0;
      bus.mem_ack = 1'b1;
      bus.dma_req = 1'b1;
      bus.ex_bus  = mk(1, 1, 1, 0, 16'h0040, 16'h0, 5'd3);
      #1;
      checks++;
      if ({bus.wb_bus, bus.mem_req, bus.mem_we, bus.dma_gnt, bus.dma_ack} !== 43'h0) begin
         errors++;
         $display("FAIL reset_outputs got wb=%h req=%b we=%b gnt=%b ack=%b want all 0",
                  bus.wb_bus, bus.mem_req, bus.mem_we, bus.dma_gnt, bus.dma_ack);
      end
      step();
      step();
      checks++;
      if (bus.dma_gnt !== 1'b0 || bus.wb_bus !== 39'h0) begin
         errors++;
         $display("FAIL reset_hold got gnt=%b wb=%h want 0", bus.dma_gnt, bus.wb_bus);
      end
      bus.mem_ack = 1'b0;
      bus.dma_req = 1'b0;
      bus.ex_bus  = '0;
      rst_n = 1'b1;
   endtask

   task automatic test_alu;
      bus.ex_bus = mk(1, 0, 0, 0, 16'h1234, 16'h0, 5'd5);
      exp_q.push_back({1'b1, 1'b0, 16'h0, 16'h1234, 5'd5});
      #1;
      checks++;
      if (bus.stall !== 1'b0 || bus.mem_req !== 1'b0) begin
         errors++;
         $display("FAIL alu_stall got stall=%b req=%b want 0 0", bus.stall, bus.mem_req);
      end
      step();
      bus.ex_bus = '0;
      #1;
      checks++;
      if (bus.wb_bus !== {1'b1, 1'b0, 16'h0, 16'h1234, 5'd5}) begin
         errors++;
         $display("FAIL alu_wb got %h want %h", bus.wb_bus, {1'b1, 1'b0, 16'h0, 16'h1234, 5'd5});
      end
   endtask

   task automatic test_back_to_back;
      logic [15:0] alu;
      logic [4:0]  rd;
      logic        m2r;
      for (int i = 0; i < 4; i++) begin
         alu = 16'($urandom);
         rd  = 5'($urandom);
         m2r = 1'($urandom);
         bus.ex_bus = mk(1, m2r, 0, 0, alu, 16'($urandom), rd);
         exp_q.push_back({1'b1, m2r, 16'h0, alu, rd});
         #1;
         checks++;
         if (bus.stall !== 1'b0 || bus.mem_req !== 1'b0) begin
            errors++;
            $display("FAIL b2b_stall op %0d got stall=%b req=%b want 0 0", i, bus.stall, bus.mem_req);
         end
         step();
      end
      cpu_access(mk(1, 1, 1, 0, 16'h0102, 16'h0, 5'd9), 16'h4321, 1);
      bus.ex_bus = mk(1, 0, 0, 0, 16'h00FF, 16'h0, 5'd1);
      exp_q.push_back({1'b1, 1'b0, 16'h0, 16'h00FF, 5'd1});
      step();
      bus.ex_bus = '0;
   endtask

   task automatic test_load;
      cpu_access(mk(1, 1, 1, 0, 16'h0040, 16'h0, 5'd7), 16'hBEEF, 3);
   endtask

   task automatic test_store;
      cpu_access(mk(0, 0, 0, 1, 16'h0010, 16'hA5A5, 5'd0), 16'h1111, 2);
   endtask

   task automatic test_rw_both;
      cpu_access(mk(1, 1, 1, 1, 16'h0020, 16'h5A5A, 5'd12), 16'hFFFF, 1);
   endtask

   // DMA tenure already granted: one write, then release
   task automatic dma_tenure;
      bus.dma_we = 1'b1; bus.dma_addr = 16'h0200; bus.dma_wdata = 16'h3C3C;
      #1;
      checks++;
      if ({bus.dma_gnt, bus.stall, bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.dma_ack}
          !== {1'b1, 1'b1, 1'b1, 1'b1, 16'h0200, 16'h3C3C, 1'b0}) begin
         errors++;
         $display("FAIL dma_own got gnt=%b stall=%b req=%b we=%b addr=%h data=%h ack=%b want 1 1 1 1 0200 3c3c 0",
                  bus.dma_gnt, bus.stall, bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.dma_ack);
      end
      bus.mem_ack = 1'b1; bus.mem_rdata = 16'h7777;
      #1;
      checks++;
      if (bus.dma_ack !== 1'b1 || bus.dma_rdata !== 16'h7777) begin
         errors++;
         $display("FAIL dma_ack got ack=%b rdata=%h want 1 7777", bus.dma_ack, bus.dma_rdata);
      end
      step();
      bus.mem_ack = 1'b0;
      bus.dma_req = 1'b0;
      #1;
      checks++;
      if ({bus.mem_req, bus.stall, bus.dma_gnt} !== 3'b011) begin
         errors++;
         $display("FAIL dma_release got req/stall/gnt=%b want 011", {bus.mem_req, bus.stall, bus.dma_gnt});
      end
      step();
      checks++;
      if (bus.dma_gnt !== 1'b0) begin
         errors++;
         $display("FAIL dma_gnt_drop got %b want 0", bus.dma_gnt);
      end
   endtask

   task automatic test_dma_same;
      bus.dma_req = 1'b1;
      cpu_access(mk(1, 1, 1, 0, 16'h0300, 16'h0, 5'd4), 16'hCAFE, 1);
      #1;
      checks++;
      if ({bus.dma_gnt, bus.mem_req, bus.stall} !== 3'b000) begin
         errors++;
         $display("FAIL dma_same_decide got gnt/req/stall=%b want 000", {bus.dma_gnt, bus.mem_req, bus.stall});
      end
      step();
      dma_tenure();
   endtask

   task automatic test_starve(input int first_delay, input bit cpu_second);
      logic [51:0] held;
      held = mk(1, 1, 1, 0, 16'h0500, 16'h0, 5'd21);
      bus.dma_req = 1'b1;
      cpu_access(mk(1, 1, 1, 0, 16'h0400, 16'h0, 5'd20), 16'h0A0A, first_delay);
      if (cpu_second) cpu_access(mk(1, 0, 1, 0, 16'h0480, 16'h0, 5'd22), 16'h0B0B, 1);
      bus.ex_bus = held;
      #1;
      checks++;
      if ({bus.mem_req, bus.stall, bus.dma_gnt} !== 3'b010) begin
         errors++;
         $display("FAIL starve_win got req/stall/gnt=%b want 010", {bus.mem_req, bus.stall, bus.dma_gnt});
      end
      step();
      dma_tenure();
      cpu_access(held, 16'h0C0C, 2);
   endtask

   task automatic test_reset_mid;
      bus.ex_bus = mk(1, 0, 0, 0, 16'h0777, 16'h0, 5'd3);
      exp_q.push_back({1'b1, 1'b0, 16'h0, 16'h0777, 5'd3});
      step();
      bus.ex_bus = '0;
      #5;
      rst_n = 1'b0;
      #1;
      checks++;
      if (bus.wb_bus !== 39'h0) begin
         errors++;
         $display("FAIL rst_async_wb got %h want 0", bus.wb_bus);
      end
      #1 rst_n = 1'b1;
      bus.ex_bus = mk(0, 0, 0, 1, 16'h0066, 16'h9999, 5'd0);
      step();
      #1;
      checks++;
      if ({bus.mem_req, bus.mem_we, bus.stall} !== 3'b111) begin
         errors++;
         $display("FAIL rst_pre_access got req/we/stall=%b want 111", {bus.mem_req, bus.mem_we, bus.stall});
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if ({bus.mem_req, bus.mem_we, bus.wb_bus} !== 41'h0) begin
         errors++;
         $display("FAIL rst_access got req=%b we=%b wb=%h want 0", bus.mem_req, bus.mem_we, bus.wb_bus);
      end
      bus.ex_bus  = '0;
      bus.dma_req = 1'b1;
      #1 rst_n = 1'b1;
      step();
      bus.mem_ack = 1'b1;
      #1;
      checks++;
      if ({bus.dma_gnt, bus.mem_req, bus.dma_ack} !== 3'b111) begin
         errors++;
         $display("FAIL rst_pre_dma got gnt/req/ack=%b want 111", {bus.dma_gnt, bus.mem_req, bus.dma_ack});
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if ({bus.dma_gnt, bus.mem_req, bus.dma_ack, bus.wb_bus} !== 42'h0) begin
         errors++;
         $display("FAIL rst_dma got gnt=%b req=%b ack=%b wb=%h want 0",
                  bus.dma_gnt, bus.mem_req, bus.dma_ack, bus.wb_bus);
      end
      bus.mem_ack = 1'b0;
      bus.dma_req = 1'b0;
      #1 rst_n = 1'b1;
      step();
   endtask

   initial begin
      test_reset();
      test_alu();
      test_back_to_back();
      test_load();
      test_store();
      test_rw_both();
      test_dma_same();
      test_starve(2, 1'b1);
      test_starve(3, 1'b0);
      test_reset_mid();
      repeat (3) step();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL wb_missing got %0d pending want 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
